req_ack_rr_arbiter: RTL
=======================

# req_ack_rr_arbiter

Round-robin scheduler that shares one req/ack data source (a `producer`, an `in` operator output, or any `async_operator` result) among `NUM_PORTS` sink channels. Sinks follow the datapath's request/acknowledge protocol: hold `req` high, then take data on the `ack` pulse. The arbiter grants one sink at a time, forwards its request upstream, and steers the returning ack and data to it. It sits between a shared operator output and the operators or consumers that read it. It replaces fixed fan-out when the sinks must not run in lockstep.

## Interface
- `NUM_PORTS`, 4: number of sink channels (2..16).
- `DATA_WIDTH`, 32: data bus width.
- `clk` input, 1: single clock, all logic on the rising edge.
- `rst` input, 1: asynchronous, active-low reset.
- `req_in` input, NUM_PORTS: per-sink request, level, held until the sink sees its ack.
- `ack_out` output, NUM_PORTS: per-sink ack, one-hot or zero. Reset value 0.
- `dout` output, DATA_WIDTH: shared data to all sinks, valid where `ack_out` is set. Reset value 0.
- `req_out` output, 1: request to the shared source. Registered. Reset value 0.
- `ack_in` input, 1: source ack pulse.
- `din` input, DATA_WIDTH: source data, valid while `ack_in` is high.
- `grant` output, $clog2(NUM_PORTS): index of the current or last grant. Reset value 0.
- `busy` output, 1: high in WAIT_ACK. Reset value 0.

## Operation
- FSM states are IDLE and WAIT_ACK. Reset enters IDLE with the rotating pointer at 0.
- IDLE, `req_in != 0`:
  - Pick the first set bit at or after `ptr`, wrapping modulo NUM_PORTS.
  - Register `grant` and set `req_out`=1.
  - Go to WAIT_ACK.
- IDLE, `req_in == 0`: stay in IDLE with `req_out`=0.
- WAIT_ACK:
  - `ack_out[grant]` = `ack_in` (combinational). All other bits are 0.
  - `dout` = `din` (combinational).
  - On a sampled `ack_in`=1: `req_out`←0, `ptr`←(grant+1) mod NUM_PORTS, go to IDLE.
- A granted sink dropping `req_in[grant]` before the ack does not abort the transfer. The ack still goes to that port, and the data is consumed or lost at the sink.
- `ack_in` while in IDLE is spurious. It is ignored: `ack_out` stays 0 and the state is unchanged.
- `req_in` changes during WAIT_ACK have no effect until IDLE.
- Asserting `rst` mid-transfer forces IDLE, `req_out`=0, `ack_out`=0, and `ptr`=0 immediately. The outstanding source ack is discarded.
- NUM_PORTS that is not a power of two: `ptr` wraps explicitly at NUM_PORTS-1 → 0. Indices ≥ NUM_PORTS are never granted.

## Timing
- Edge n samples a sink `req_in` that rose in the cycle before edge n. At edge n the arbiter registers `req_out`=1 and `grant`.
- A producer-style source answers with `ack_in` after edge n+1.
- `ack_out` is high in the same cycle as `ack_in`, with zero added latency.
- The FSM returns to IDLE at edge n+2. The earliest next grant is edge n+3. Steady state is one transfer per 3 cycles with an ideal source.
- The sink drops its req at the same edge n+2. IDLE therefore samples the updated `req_in` at n+3, so there is no duplicate grant.
- Fairness: with all ports requesting continuously, grants run 0,1,2,…,N-1,0. Maximum wait is N-1 transfers.

## Configuration
- `REQ_ACK_ARB_STATS_EN` defined:
  - Adds output `grant_count`, NUM_PORTS×32. It holds a saturating 32-bit count of acks delivered per port.
  - Adds output `spurious_count`, 32. It counts `ack_in` pulses seen in IDLE, saturating.
  - Both counters clear on reset.
- Undefined: neither port exists and no counters are built. The functional behaviour is identical.

## Structure
- Package `req_ack_arb_pkg`: state enum (IDLE, WAIT_ACK), the `IDX_W(n)` width function, and the counter width constant 32.
- Sub-module `rr_pick`: combinational rotating-priority selector. Inputs are `req`, `ptr`; outputs are `idx`, `valid`. It is instantiated once.

## Test plan
- Single sink: port 2 requests and the source returns din=0x1234. Expect req_out high one cycle after the request, `ack_out`=4'b0100, `dout`=0x1234, grant=2.
- All four ports request continuously with an ideal producer for 12 transfers. Expect grant order 0,1,2,3,0,1,2,3,0,1,2,3 and exactly 3 acks per port.
- Ports 1 and 3 request, with ptr=2 after a prior grant on port 1. Expect port 3 granted first, then port 1.
- Source delays ack by 10 cycles while port 0 is granted and port 1 requests. Expect `req_out` held high, `busy`=1 for 11 cycles, and no grant change until the ack.
- Reset asserted during WAIT_ACK, with `ack_in` arriving 1 cycle after release. Expect `req_out`=0, `ack_out`=0, and with the macro defined, `spurious_count`=1.
- With `REQ_ACK_ARB_STATS_EN`, 5000 transfers spread over 4 ports. Expect the sum of `grant_count` to be 5000 and each port count to be 1250.

Source files
------------

// File: rtl/req_ack_rr_arbiter_pkg.sv
// Shared types and helpers for the req/ack round-robin arbiter.
package req_ack_arb_pkg;

  localparam int unsigned CNT_W = 32;

  typedef enum logic [0:0] {
    StIdle,
    StWaitAck
  } state_e;

  // Index width that stays at least one bit wide for degenerate sizes.
  function automatic int unsigned IDX_W(int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/req_ack_rr_arbiter_if.sv
// Handshake bundle between the shared source, the sinks and the arbiter.
interface req_ack_rr_arbiter_if #(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned IdxW = req_ack_arb_pkg::IDX_W(NUM_PORTS);

  logic [NUM_PORTS-1:0]  req_in;
  logic [NUM_PORTS-1:0]  ack_out;
  logic [DATA_WIDTH-1:0] dout;
  logic                  req_out;
  logic                  ack_in;
  logic [DATA_WIDTH-1:0] din;
  logic [IdxW-1:0]       grant;
  logic                  busy;

  // master: the arbiter; slave: the source/sink environment around it
  modport master (
    input  req_in, ack_in, din,
    output ack_out, dout, req_out, grant, busy
  );

  modport slave (
    output req_in, ack_in, din,
    input  ack_out, dout, req_out, grant, busy
  );

endinterface

// File: rtl/req_ack_rr_arbiter_rr_pick.sv
// Combinational rotating-priority selector: first set request at or after ptr, wrapping.
module rr_pick
  import req_ack_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  localparam int unsigned IdxW     = IDX_W(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IdxW-1:0]      ptr_i,
  output logic [IdxW-1:0]      idx_o,
  output logic                 valid_o
);

  always_comb begin
    int unsigned cand;
    logic [IdxW-1:0] cand_idx;
    idx_o    = '0;
    valid_o  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      cand = 32'(ptr_i) + k;
      // explicit wrap keeps non-power-of-two port counts in range
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      cand_idx = IdxW'(cand);
      if (!valid_o && req_i[cand_idx]) begin
        valid_o = 1'b1;
        idx_o   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/req_ack_rr_arbiter.sv
// Round-robin arbiter sharing one req/ack source among NUM_PORTS sinks.
// Optional per-port/spurious ack counters when REQ_ACK_ARB_STATS_EN is defined.
module req_ack_rr_arbiter
  import req_ack_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  req_ack_rr_arbiter_if.master            bus
`ifdef REQ_ACK_ARB_STATS_EN
  ,
  output logic [NUM_PORTS-1:0][CNT_W-1:0] grant_count_o,
  output logic [CNT_W-1:0]                spurious_count_o
`endif
);

  localparam int unsigned IdxW = IDX_W(NUM_PORTS);

  state_e                state_q, state_d;
  logic [IdxW-1:0]       grant_q, grant_d;
  logic [IdxW-1:0]       ptr_q, ptr_d;
  logic                  req_out_q, req_out_d;
  logic [IdxW-1:0]       pick_idx;
  logic                  pick_valid;
  logic [NUM_PORTS-1:0]  ack_out;
  logic [DATA_WIDTH-1:0] dout;

  rr_pick #(
    .NUM_PORTS(NUM_PORTS)
  ) u_rr_pick (
    .req_i  (bus.req_in),
    .ptr_i  (ptr_q),
    .idx_o  (pick_idx),
    .valid_o(pick_valid)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    ack_out = '0;
    dout    = '0;
    case (state_q)
      StIdle: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          state_d = StWaitAck;
        end
      end
      StWaitAck: begin
        // ack and data pass straight through to the granted sink
        ack_out[grant_q] = bus.ack_in;
        dout             = bus.din;
        if (bus.ack_in) begin
          ptr_d   = (grant_q == IdxW'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    req_out_d = (state_d == StWaitAck);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      ptr_q     <= '0;
      req_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      req_out_q <= req_out_d;
    end
  end

  assign bus.ack_out = ack_out;
  assign bus.dout    = dout;
  assign bus.req_out = req_out_q;
  assign bus.grant   = grant_q;
  assign bus.busy    = (state_q == StWaitAck);

`ifdef REQ_ACK_ARB_STATS_EN
  logic [NUM_PORTS-1:0][CNT_W-1:0] grant_cnt_q, grant_cnt_d;
  logic [CNT_W-1:0]                spur_cnt_q, spur_cnt_d;

  always_comb begin
    grant_cnt_d = grant_cnt_q;
    spur_cnt_d  = spur_cnt_q;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (ack_out[i] && (grant_cnt_q[i] != '1)) grant_cnt_d[i] = grant_cnt_q[i] + CNT_W'(1);
    end
    if ((state_q == StIdle) && bus.ack_in && (spur_cnt_q != '1)) begin
      spur_cnt_d = spur_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grant_cnt_q <= '0;
      spur_cnt_q  <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      spur_cnt_q  <= spur_cnt_d;
    end
  end

  assign grant_count_o    = grant_cnt_q;
  assign spurious_count_o = spur_cnt_q;
`endif

endmodule
